// File: rtl/next_pc_logic.sv
// Fetch-stage next-PC selection: sequential PC+4 or PC-relative branch target,
// plus the architectural PC register loaded from the selected address.
module next_pc_logic #(
  parameter int unsigned           WIDTH       = 64,
  parameter logic [WIDTH-1:0]      RESET_PC    = '0,
  parameter int unsigned           IMM_SHIFT   = 2,
  parameter int unsigned           INSTR_BYTES = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] currentPC,
  input  logic [WIDTH-1:0] imm,
  input  logic             branchCond,
  input  logic             aluZero,
  input  logic             uncondBranch,
  output logic [WIDTH-1:0] nextPC,
  output logic             branchTaken,
  output logic [WIDTH-1:0] pcReg
);

  logic [WIDTH-1:0] seqPC;
  logic [WIDTH-1:0] immBytes;
  logic [WIDTH-1:0] target;

  // Left shift of a two's-complement offset is sign-correct modulo 2^WIDTH,
  // so no explicit sign extension is needed; carries out of the top drop.
  always_comb begin
    immBytes    = imm << IMM_SHIFT;
    seqPC       = currentPC + WIDTH'(INSTR_BYTES);
    target      = currentPC + immBytes;
    branchTaken = uncondBranch | (branchCond & aluZero);
    nextPC      = branchTaken ? target : seqPC;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      pcReg <= RESET_PC;
    end else begin
      pcReg <= nextPC;
    end
  end

endmodule

// File: tb/tb_next_pc_logic.sv
// Bench for next_pc_logic: directed vector table, reset sequence, and random
// stimulus checked against an arithmetic reference model.
module tb_next_pc_logic;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [63:0] currentPC;
  logic [63:0] imm;
  logic        branchCond;
  logic        aluZero;
  logic        uncondBranch;
  logic [63:0] nextPC;
  logic        branchTaken;
  logic [63:0] pcReg;

  int nVec = 0;
  int nErr = 0;

  next_pc_logic dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .currentPC   (currentPC),
    .imm         (imm),
    .branchCond  (branchCond),
    .aluZero     (aluZero),
    .uncondBranch(uncondBranch),
    .nextPC      (nextPC),
    .branchTaken (branchTaken),
    .pcReg       (pcReg)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [63:0] pc;
    logic [63:0] imm;
    logic        bc;
    logic        az;
    logic        ub;
    logic [63:0] expNext;
    logic        expTaken;
  } vec_t;

  vec_t vecs[$];

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference: signed word offset scaled by multiplication, 64-bit wrap.
  function automatic logic [63:0] modelNext(input logic [63:0] pc, input logic [63:0] off,
                                            input logic bc, input logic az, input logic ub,
                                            output logic taken);
    longint signed words;
    longint signed bytesOff;
    taken    = ub || (bc && az);
    words    = $signed(off);
    bytesOff = words * 4;
    if (taken) return pc + 64'(bytesOff);
    return pc + 64'd4;
  endfunction

  task automatic drive(input logic [63:0] pc, input logic [63:0] im,
                       input logic bc, input logic az, input logic ub);
    currentPC    = pc;
    imm          = im;
    branchCond   = bc;
    aluZero      = az;
    uncondBranch = ub;
  endtask

  initial begin
    logic [63:0] expN;
    logic        expT;

    vecs.push_back('{"seq",        64'h1000, 64'd0, 1'b0, 1'b0, 1'b0, 64'h1004, 1'b0});
    vecs.push_back('{"condTaken",  64'h1000, 64'd2, 1'b1, 1'b1, 1'b0, 64'h1008, 1'b1});
    vecs.push_back('{"uncond1",    64'h1000, 64'd1, 1'b0, 1'b0, 1'b1, 64'h1004, 1'b1});
    vecs.push_back('{"uncond5",    64'h1000, 64'd5, 1'b0, 1'b0, 1'b1, 64'h1014, 1'b1});
    vecs.push_back('{"condNot",    64'h1000, 64'd2, 1'b1, 1'b0, 1'b0, 64'h1004, 1'b0});
    vecs.push_back('{"backward",   64'h1000, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1,
                     64'h0FF8, 1'b1});
    vecs.push_back('{"wrapSeq",    64'hFFFF_FFFF_FFFF_FFFC, 64'd7, 1'b0, 1'b0, 1'b0,
                     64'h0, 1'b0});
    vecs.push_back('{"zeroOnly",   64'h2000, 64'd9, 1'b0, 1'b1, 1'b0, 64'h2004, 1'b0});
    vecs.push_back('{"uncondPrio", 64'h2000, 64'd3, 1'b1, 1'b0, 1'b1, 64'h200C, 1'b1});
    vecs.push_back('{"wrapTarget", 64'hFFFF_FFFF_FFFF_FFF0, 64'd8, 1'b1, 1'b1, 1'b0,
                     64'h10, 1'b1});

    // Reset state
    Reset = 1'b1;
    drive(64'h1000, 64'd0, 1'b0, 1'b0, 1'b0);
    @(posedge CLK); #1;
    check64("resetPcReg", pcReg, 64'h0);
    Reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].pc, vecs[i].imm, vecs[i].bc, vecs[i].az, vecs[i].ub);
      #1;
      check64({vecs[i].name, ".nextPC"}, nextPC, vecs[i].expNext);
      check1({vecs[i].name, ".branchTaken"}, branchTaken, vecs[i].expTaken);
      @(posedge CLK); #1;
      check64({vecs[i].name, ".pcReg"}, pcReg, vecs[i].expNext);
    end

    // Reset overrides a selected branch to 0x2000, then release loads it
    drive(64'h1000, 64'h400, 1'b0, 1'b0, 1'b1);
    Reset = 1'b1;
    #1;
    check64("resetBranch.nextPC", nextPC, 64'h2000);
    check1("resetBranch.branchTaken", branchTaken, 1'b1);
    @(posedge CLK); #1;
    check64("resetBranch.pcReg", pcReg, 64'h0);
    Reset = 1'b0;
    @(posedge CLK); #1;
    check64("releaseBranch.pcReg", pcReg, 64'h2000);

    // Randomized against the reference model
    for (int n = 0; n < 300; n++) begin
      logic [63:0] rp;
      logic [63:0] ri;
      rp = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rp = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      ri = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) ri = 64'($signed($urandom_range(0, 2000)) - 1000);
      drive(rp, ri, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
      expN = modelNext(rp, ri, branchCond, aluZero, uncondBranch, expT);
      #1;
      check64("rand.nextPC", nextPC, expN);
      check1("rand.branchTaken", branchTaken, expT);
      @(posedge CLK); #1;
      check64("rand.pcReg", pcReg, expN);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/next_pc_logic.md
Name: next_pc_logic

Overview:
- Computes the next program counter for the single-cycle CPU fetch stage.
- Selects between the sequential address (PC + 4) and a PC-relative branch target (PC + imm×4).
- The selection is driven by the unconditional-branch, conditional-branch and ALU-zero control signals.
- Provides a combinational nextPC and a registered copy (pcReg) that serves as the architectural PC register.

Parameters:
- WIDTH, 64, address/immediate width in bits.
- RESET_PC, 64'h0, value loaded into pcReg on reset.
- IMM_SHIFT, 2, left shift applied to imm (word offset to byte offset).
- INSTR_BYTES, 4, sequential increment.

Ports:
- CLK  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- currentPC  input  WIDTH  PC of the instruction being executed.
- imm  input  WIDTH  sign-extended branch offset in instruction words (two's complement).
- branchCond  input  1  instruction is a conditional branch.
- aluZero  input  1  ALU zero flag from the current instruction.
- uncondBranch  input  1  instruction is an unconditional branch.
- nextPC  output  WIDTH  combinational next PC.
- branchTaken  output  1  combinational: a branch target was selected.
- pcReg  output  WIDTH  registered nextPC (architectural PC).

Behaviour:
Combinational path (no clock dependence):
- seqPC = currentPC + INSTR_BYTES.
- target = currentPC + (imm << IMM_SHIFT).
- All arithmetic is WIDTH-bit modulo 2^WIDTH: wrap-around is silent and the carry is discarded.
- imm is treated as signed, so negative offsets branch backward. Bits shifted out of the top are discarded.
- branchTaken = uncondBranch | (branchCond & aluZero).
- nextPC = branchTaken ? target : seqPC.
- uncondBranch has priority: it takes the branch regardless of branchCond and aluZero.
- branchCond=1 with aluZero=0 is not taken, so nextPC = seqPC.
- aluZero alone (branchCond=0, uncondBranch=0) has no effect.
- Output delay: nextPC must settle within 1 ns of any input change in simulation. Any modelled gate delays total ≤1 ns.
- nextPC and branchTaken are unaffected by Reset.

Registered path:
- On a rising CLK edge with Reset=1: pcReg <= RESET_PC.
- On a rising CLK edge with Reset=0: pcReg <= nextPC.
- There is no enable; pcReg updates every cycle.
- Latency: pcReg reflects nextPC one cycle after the inputs are applied.
- Reset asserted mid-operation takes effect at the next edge, overriding any branch.
- Before the first clock edge pcReg is X. The bench applies Reset for at least one edge.

X handling:
- X on any control bit may propagate X to nextPC.
- There are no internal assertions.

Test Plan:
- Sequential: currentPC=0x1000, imm=0, branchCond=0, aluZero=0, uncondBranch=0 -> nextPC=0x1004, branchTaken=0; after a CLK edge, pcReg=0x1004.
- Conditional taken: currentPC=0x1000, imm=2, branchCond=1, aluZero=1 -> nextPC=0x1008, branchTaken=1.
- Unconditional: currentPC=0x1000, imm=1, uncondBranch=1, branchCond=0, aluZero=0 -> nextPC=0x1004, branchTaken=1.
  - Repeat with imm=5 -> nextPC=0x1014.
- Conditional not taken: currentPC=0x1000, imm=2, branchCond=1, aluZero=0 -> nextPC=0x1004, branchTaken=0.
- Backward branch and wrap:
  - currentPC=0x1000, imm=64'hFFFF_FFFF_FFFF_FFFE, uncondBranch=1 -> nextPC=0x0FF8.
  - currentPC=64'hFFFF_FFFF_FFFF_FFFC, no branch -> nextPC=0x0.
- Reset: hold Reset=1 while a branch to 0x2000 is selected -> pcReg=0x0 after the edge. Release Reset -> pcReg=0x2000 after the next edge.
